// File: rtl/brq_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : brq_pkg
//  Description : Shared types and constants for the IFU fetch FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package brq_pkg;

    // Low two bits of an uncompressed (32-bit) instruction
    localparam logic [1:0] c_uncomp_lsb = 2'b11;

    // One fetched word as held in a FIFO entry
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        valid;
    } fifo_entry_t;

endpackage
`default_nettype wire

// File: rtl/brq_ifu_fifo_if.sv
`default_nettype none
// ============================================================================
//  Interface   : brq_ifu_fifo_if
//  Description : Fetch-word input and aligned-instruction output bundle of
//                the IFU fetch FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
interface brq_ifu_fifo_if;

    // Fetched word side
    logic        in_valid_i;
    logic [31:0] in_addr_i;
    logic [31:0] in_rdata_i;
    logic        in_err_i;

    // Aligned instruction side
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_addr_o;
    logic [31:0] out_addr_next_o;
    logic [31:0] out_rdata_o;
    logic        out_err_o;
    logic        out_err_plus2_o;

    // Prefetch buffer: produces words, consumes instructions
    modport master (
        output in_valid_i, in_addr_i, in_rdata_i, in_err_i, out_ready_i,
        input  out_valid_o, out_addr_o, out_addr_next_o, out_rdata_o,
               out_err_o, out_err_plus2_o
    );

    // FIFO: consumes words, produces instructions
    modport slave (
        input  in_valid_i, in_addr_i, in_rdata_i, in_err_i, out_ready_i,
        output out_valid_o, out_addr_o, out_addr_next_o, out_rdata_o,
               out_err_o, out_err_plus2_o
    );

endinterface
`default_nettype wire

// File: rtl/brq_ifu_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : brq_ifu_fifo
//  Description : Fetch FIFO that realigns 32-bit fetch words into compressed
//                (16-bit) or uncompressed (32-bit) instructions.
//                Optional macro BRQ_IFU_FIFO_BYPASS_EN: when entry 0 is empty
//                an incoming word drives the outputs in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module brq_ifu_fifo
    import brq_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    input  wire logic             clear_i,
    output logic [DEPTH-1:0]      busy_o,
    brq_ifu_fifo_if.slave         bus
);

    fifo_entry_t r_entries [DEPTH];
    fifo_entry_t w_next    [DEPTH];
    logic [31:0] r_addr;

    fifo_entry_t w_e0;
    fifo_entry_t w_e1;
    logic        w_bypass;
    logic        w_aligned;
    logic        w_hi_uncomp;
    logic [31:0] w_rdata;
    logic        w_valid;
    logic        w_err;
    logic        w_err_plus2;
    logic        w_fire;
    logic        w_pop;
    logic        w_pop_reg;
    logic        w_push;
    logic        w_full;
    logic        w_placed;

    // Select the word(s) presented as entry 0/1, optionally from the input
    always_comb begin
        w_e0     = r_entries[0];
        w_e1     = r_entries[1];
        w_bypass = 1'b0;
`ifdef BRQ_IFU_FIFO_BYPASS_EN
        if (!r_entries[0].valid && bus.in_valid_i && !clear_i) begin
            w_bypass = 1'b1;
            w_e0     = '{rdata: bus.in_rdata_i, err: bus.in_err_i, valid: 1'b1};
        end
`endif
    end

    // Realign the instruction according to the halfword offset of the PC
    always_comb begin
        w_aligned   = ~r_addr[1];
        w_hi_uncomp = (w_e0.rdata[17:16] == c_uncomp_lsb);
        w_err_plus2 = 1'b0;
        if (w_aligned) begin
            w_rdata = w_e0.rdata;
            w_valid = w_e0.valid;
            w_err   = w_e0.err;
        end else if (!w_hi_uncomp) begin
            w_rdata = {16'h0000, w_e0.rdata[31:16]};
            w_valid = w_e0.valid;
            w_err   = w_e0.err;
        end else begin
            // Instruction straddles entries 0 and 1; an error on word 0
            // alone is enough to hand the instruction out
            w_rdata     = {w_e1.rdata[15:0], w_e0.rdata[31:16]};
            w_valid     = w_e0.valid & (w_e1.valid | w_e0.err);
            w_err       = w_e0.err | (w_e1.err & w_e1.valid);
            w_err_plus2 = w_e1.err & w_e1.valid & ~w_e0.err;
        end
    end

    assign bus.out_valid_o     = w_valid;
    assign bus.out_rdata_o     = w_rdata;
    assign bus.out_err_o       = w_err;
    assign bus.out_err_plus2_o = w_err_plus2;
    assign bus.out_addr_o      = r_addr;
    assign bus.out_addr_next_o = r_addr + ((w_rdata[1:0] == c_uncomp_lsb) ? 32'd4 : 32'd2);

    // An aligned compressed instruction leaves the upper half in entry 0.
    // A bypassed word that is fully consumed is never stored.
    assign w_fire    = w_valid & bus.out_ready_i;
    assign w_pop     = w_fire & ~(w_aligned & (w_rdata[1:0] != c_uncomp_lsb));
    assign w_pop_reg = w_pop & r_entries[0].valid;
    assign w_push    = bus.in_valid_i & ~(w_bypass & w_pop);

    // Shift on pop, then place the new word in the lowest free slot
    always_comb begin
        w_next   = r_entries;
        w_placed = 1'b0;
        if (w_pop_reg) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                w_next[i] = r_entries[i + 1];
            end
            w_next[DEPTH-1] = '0;
        end
        if (w_push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!w_placed && !w_next[i].valid) begin
                    w_next[i] = '{rdata: bus.in_rdata_i, err: bus.in_err_i, valid: 1'b1};
                    w_placed  = 1'b1;
                end
            end
        end
    end

    // Entry storage and instruction address; reset beats clear beats push/pop
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
            r_addr <= 32'h0;
        end else if (clear_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
            r_addr <= {bus.in_addr_i[31:1], 1'b0};
        end else begin
            r_entries <= w_next;
            if (w_fire) begin
                r_addr <= bus.out_addr_next_o;
            end
        end
    end

    // Occupancy flags for fetch flow control
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_busy
        assign busy_o[gi] = r_entries[gi].valid;
    end

    always_comb begin
        w_full = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            w_full = w_full & r_entries[i].valid;
        end
    end

    // Pushing into a full FIFO without a pop loses the word
    a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
        !(bus.in_valid_i && !clear_i && w_full && !w_pop_reg));

endmodule
`default_nettype wire

// File: tb/tb_brq_ifu_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_brq_ifu_fifo
//  Description : Directed self-checking bench for brq_ifu_fifo.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_brq_ifu_fifo;

    localparam int DEPTH = 3;

`ifdef BRQ_IFU_FIFO_BYPASS_EN
    localparam logic c_push_cycle_valid = 1'b1;
`else
    localparam logic c_push_cycle_valid = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic [DEPTH-1:0] busy;
    int               n_cmp = 0;
    int               n_err = 0;

    brq_ifu_fifo_if u_if ();

    brq_ifu_fifo #(.DEPTH(DEPTH)) u_dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (clear),
        .busy_o  (busy),
        .bus     (u_if.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear(input logic [31:0] addr);
        clear = 1'b1; u_if.in_addr_i = addr;
        tick();
        clear = 1'b0;
    endtask

    task automatic push(input logic [31:0] data, input logic err);
        u_if.in_valid_i = 1'b1; u_if.in_rdata_i = data; u_if.in_err_i = err;
        tick();
        u_if.in_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_cmp++; if (u_if.out_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", u_if.out_valid_o); end
        n_cmp++; if (busy !== 3'b000) begin n_err++; $display("FAIL reset_busy: got %b want 000", busy); end
        n_cmp++; if (u_if.out_addr_o !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", u_if.out_addr_o); end
        n_cmp++; if (u_if.out_err_o !== 1'b0 || u_if.out_err_plus2_o !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b%b want 00", u_if.out_err_o, u_if.out_err_plus2_o); end
        rst = 1'b0;
    endtask

    task automatic test_aligned();
        do_clear(32'h80);
        n_cmp++; if (u_if.out_addr_o !== 32'h80) begin n_err++; $display("FAIL clear_addr: got %h want 80", u_if.out_addr_o); end
        u_if.in_valid_i = 1'b1; u_if.in_rdata_i = 32'h0041_0113; u_if.in_err_i = 1'b0;
        #1;
        n_cmp++; if (u_if.out_valid_o !== c_push_cycle_valid) begin n_err++; $display("FAIL push_cycle_valid: got %b want %b", u_if.out_valid_o, c_push_cycle_valid); end
        tick();
        u_if.in_valid_i = 1'b0;
        n_cmp++; if (u_if.out_valid_o !== 1'b1) begin n_err++; $display("FAIL al_valid: got %b want 1", u_if.out_valid_o); end
        n_cmp++; if (u_if.out_rdata_o !== 32'h0041_0113) begin n_err++; $display("FAIL al_rdata: got %h want 00410113", u_if.out_rdata_o); end
        n_cmp++; if (u_if.out_addr_next_o !== 32'h84) begin n_err++; $display("FAIL al_next: got %h want 84", u_if.out_addr_next_o); end
        u_if.out_ready_i = 1'b1; tick(); u_if.out_ready_i = 1'b0;
        n_cmp++; if (busy !== 3'b000 || u_if.out_valid_o !== 1'b0) begin n_err++; $display("FAIL al_pop: got busy %b valid %b want 000 0", busy, u_if.out_valid_o); end
        n_cmp++; if (u_if.out_addr_o !== 32'h84) begin n_err++; $display("FAIL al_addr: got %h want 84", u_if.out_addr_o); end
    endtask

    task automatic test_compressed_hi();
        do_clear(32'h82);
        push(32'h4501_1234, 1'b0);
        n_cmp++; if (u_if.out_valid_o !== 1'b1 || u_if.out_rdata_o[15:0] !== 16'h4501) begin n_err++; $display("FAIL chi_data: got %b %h want 1 4501", u_if.out_valid_o, u_if.out_rdata_o[15:0]); end
        n_cmp++; if (u_if.out_addr_next_o !== 32'h84) begin n_err++; $display("FAIL chi_next: got %h want 84", u_if.out_addr_next_o); end
        u_if.out_ready_i = 1'b1; tick(); u_if.out_ready_i = 1'b0;
        n_cmp++; if (busy !== 3'b000 || u_if.out_addr_o !== 32'h84) begin n_err++; $display("FAIL chi_pop: got busy %b addr %h want 000 84", busy, u_if.out_addr_o); end
    endtask

    task automatic test_unaligned();
        do_clear(32'h82);
        push(32'h0013_abcd, 1'b0);
        n_cmp++; if (u_if.out_valid_o !== 1'b0 || busy !== 3'b001) begin n_err++; $display("FAIL ua_half: got valid %b busy %b want 0 001", u_if.out_valid_o, busy); end
        push(32'h1234_0050, 1'b0);
        n_cmp++; if (u_if.out_valid_o !== 1'b1 || u_if.out_rdata_o !== 32'h0050_0013) begin n_err++; $display("FAIL ua_rdata: got %b %h want 1 00500013", u_if.out_valid_o, u_if.out_rdata_o); end
        n_cmp++; if (u_if.out_addr_next_o !== 32'h86) begin n_err++; $display("FAIL ua_next: got %h want 86", u_if.out_addr_next_o); end
        n_cmp++; if (u_if.out_err_o !== 1'b0 || u_if.out_err_plus2_o !== 1'b0) begin n_err++; $display("FAIL ua_err: got %b%b want 00", u_if.out_err_o, u_if.out_err_plus2_o); end
        u_if.out_ready_i = 1'b1; tick(); u_if.out_ready_i = 1'b0;
        n_cmp++; if (busy !== 3'b001 || u_if.out_addr_o !== 32'h86) begin n_err++; $display("FAIL ua_pop: got busy %b addr %h want 001 86", busy, u_if.out_addr_o); end
        n_cmp++; if (u_if.out_rdata_o !== 32'h0000_1234 || u_if.out_addr_next_o !== 32'h88) begin n_err++; $display("FAIL ua_tail: got %h next %h want 00001234 88", u_if.out_rdata_o, u_if.out_addr_next_o); end
    endtask

    task automatic test_err();
        do_clear(32'h82);
        push(32'h0013_0000, 1'b0);
        push(32'h0000_0050, 1'b1);
        n_cmp++; if (u_if.out_valid_o !== 1'b1 || u_if.out_err_o !== 1'b1 || u_if.out_err_plus2_o !== 1'b1) begin n_err++; $display("FAIL err2: got v%b e%b p%b want 111", u_if.out_valid_o, u_if.out_err_o, u_if.out_err_plus2_o); end
        do_clear(32'h82);
        push(32'h0013_0000, 1'b1);
        n_cmp++; if (u_if.out_valid_o !== 1'b1 || u_if.out_err_o !== 1'b1 || u_if.out_err_plus2_o !== 1'b0) begin n_err++; $display("FAIL err1_only: got v%b e%b p%b want 110", u_if.out_valid_o, u_if.out_err_o, u_if.out_err_plus2_o); end
        push(32'h0000_0050, 1'b1);
        n_cmp++; if (u_if.out_err_o !== 1'b1 || u_if.out_err_plus2_o !== 1'b0) begin n_err++; $display("FAIL err12: got e%b p%b want 10", u_if.out_err_o, u_if.out_err_plus2_o); end
    endtask

    task automatic test_fill();
        logic [31:0] words [4];
        logic [31:0] exp_addr;
        words = '{32'h0000_0113, 32'h0000_0213, 32'h0000_0313, 32'h0000_0413};
        do_clear(32'h0);
        for (int i = 0; i < DEPTH; i++) push(words[i], 1'b0);
        n_cmp++; if (busy !== 3'b111 || u_if.out_rdata_o !== words[0]) begin n_err++; $display("FAIL fill: got busy %b rdata %h want 111 %h", busy, u_if.out_rdata_o, words[0]); end
        // simultaneous push and pop keeps occupancy
        u_if.out_ready_i = 1'b1;
        push(words[3], 1'b0);
        u_if.out_ready_i = 1'b0;
        n_cmp++; if (busy !== 3'b111 || u_if.out_rdata_o !== words[1]) begin n_err++; $display("FAIL push_pop: got busy %b rdata %h want 111 %h", busy, u_if.out_rdata_o, words[1]); end
        exp_addr = 32'h4;
        u_if.out_ready_i = 1'b1;
        for (int i = 1; i < 4; i++) begin
            n_cmp++; if (u_if.out_rdata_o !== words[i] || u_if.out_addr_o !== exp_addr) begin n_err++; $display("FAIL drain%0d: got %h @%h want %h @%h", i, u_if.out_rdata_o, u_if.out_addr_o, words[i], exp_addr); end
            tick();
            exp_addr = exp_addr + 32'd4;
        end
        u_if.out_ready_i = 1'b0;
        n_cmp++; if (busy !== 3'b000 || u_if.out_addr_o !== 32'h10) begin n_err++; $display("FAIL drained: got busy %b addr %h want 000 10", busy, u_if.out_addr_o); end
        // clear drops a concurrent input word
        u_if.in_valid_i = 1'b1; u_if.in_rdata_i = words[0]; u_if.in_err_i = 1'b0;
        do_clear(32'h101);
        u_if.in_valid_i = 1'b0;
        n_cmp++; if (busy !== 3'b000 || u_if.out_valid_o !== 1'b0 || u_if.out_addr_o !== 32'h100) begin n_err++; $display("FAIL clear_drop: got busy %b v%b addr %h want 000 0 100", busy, u_if.out_valid_o, u_if.out_addr_o); end
    endtask

    task automatic test_wrap();
        do_clear(32'hffff_ffff);
        push(32'h4501_0000, 1'b0);
        n_cmp++; if (u_if.out_addr_o !== 32'hffff_fffe || u_if.out_addr_next_o !== 32'h0) begin n_err++; $display("FAIL wrap_next: got %h -> %h want fffffffe -> 0", u_if.out_addr_o, u_if.out_addr_next_o); end
        u_if.out_ready_i = 1'b1; tick(); u_if.out_ready_i = 1'b0;
        n_cmp++; if (u_if.out_addr_o !== 32'h0 || busy !== 3'b000) begin n_err++; $display("FAIL wrap_pop: got %h busy %b want 0 000", u_if.out_addr_o, busy); end
    endtask

    task automatic test_reset_mid();
        do_clear(32'h82);
        push(32'h0013_0000, 1'b0);
        rst = 1'b1; clear = 1'b1; u_if.out_ready_i = 1'b1;
        u_if.in_valid_i = 1'b1; u_if.in_rdata_i = 32'h0000_0050; u_if.in_addr_i = 32'h200;
        tick();
        rst = 1'b0; clear = 1'b0; u_if.out_ready_i = 1'b0; u_if.in_valid_i = 1'b0;
        n_cmp++; if (busy !== 3'b000 || u_if.out_valid_o !== 1'b0 || u_if.out_addr_o !== 32'h0) begin n_err++; $display("FAIL reset_mid: got busy %b v%b addr %h want 000 0 0", busy, u_if.out_valid_o, u_if.out_addr_o); end
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0;
        u_if.in_valid_i = 1'b0; u_if.in_addr_i = '0; u_if.in_rdata_i = '0;
        u_if.in_err_i = 1'b0; u_if.out_ready_i = 1'b0;
        test_reset();
        test_aligned();
        test_compressed_hi();
        test_unaligned();
        test_err();
        test_fill();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
